// File: rtl/modulo_contador_sync_7_bits_ascendente.sv
// modulo_contador_sync_7_bits_ascendente
// Synchronous 7-bit up-counter with parallel load, count enable, programmable
// terminal value and a three-state control FSM (IDLE / COUNT / DONE).
// Optional feature macro: CONTADOR_ASC_AUTO_RECARGA_EN
//   defined   -> on terminal count, q reloads from carga and keeps counting
//   undefined -> on terminal count, the FSM parks in DONE with q at limite
module modulo_contador_sync_7_bits_ascendente (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       en,
    input  logic [6:0] e,
    input  logic [6:0] limite,
    output logic [6:0] q,
    output logic [6:0] q_bar,
    output logic       busy,
    output logic       done,
    output logic       tc
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [6:0] q_nxt;
    logic [6:0] carga;
    logic [6:0] carga_nxt;
    logic       tc_nxt;
    logic       at_limit;

    // limite is compared live every cycle, so a mid-count change takes effect at once
    assign at_limit = (q == limite);

    // State, count, reload value and tc pulse register; rst beats everything
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling the
        // pre-edge values, so ordering between these lines does not matter.
        if (rst) begin
            state <= IDLE;
            q     <= 7'd0;
            carga <= 7'd0;
            tc    <= 1'b0;
        end else begin
            state <= state_nxt;
            q     <= q_nxt;
            carga <= carga_nxt;
            tc    <= tc_nxt;
        end
    end

    // Next-state logic: load overrides the FSM; otherwise IDLE/COUNT step on en
    always_comb begin
        // NOTE: every output of this block gets a hold/default value first so
        // no path through the case statement can infer a latch.
        state_nxt = state;
        q_nxt     = q;
        carga_nxt = carga;
        tc_nxt    = 1'b0;

        if (load) begin
            q_nxt     = e;
            carga_nxt = e;
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, COUNT: begin
                    if (en) begin
                        if (at_limit) begin
                            tc_nxt = 1'b1;
`ifdef CONTADOR_ASC_AUTO_RECARGA_EN
                            // Continuous mode: restart from the loaded value
                            q_nxt     = carga;
                            state_nxt = COUNT;
`else
                            // One-shot mode: q already equals limite, just park
                            state_nxt = DONE;
`endif
                        end else begin
                            // Modulo-128 step; 127 wraps naturally to 0
                            q_nxt     = q + 7'd1;
                            state_nxt = COUNT;
                        end
                    end
                end
                DONE: begin
                    // Terminal: only load or rst leave this state
                    state_nxt = DONE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Outputs decoded from registered state, so they move together with q
    assign q_bar = ~q;
    assign busy  = (state == COUNT);
    assign done  = (state == DONE);

endmodule

// File: tb/tb_modulo_contador_sync_7_bits_ascendente.sv
// Self-checking bench for modulo_contador_sync_7_bits_ascendente.
// Table of {inputs, expected outputs after the edge}, plus hand-written
// multi-cycle sequences. Expectations are queued when stimulus is driven and
// popped for comparison once the DUT has clocked.
module tb_modulo_contador_sync_7_bits_ascendente;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load = 1'b0;
    logic       en = 1'b0;
    logic [6:0] e = 7'd0;
    logic [6:0] limite = 7'd0;
    logic [6:0] q;
    logic [6:0] q_bar;
    logic       busy;
    logic       done;
    logic       tc;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       rst;
        logic       load;
        logic       en;
        logic [6:0] e;
        logic [6:0] limite;
        logic [6:0] q;
        logic       busy;
        logic       done;
        logic       tc;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    modulo_contador_sync_7_bits_ascendente dut (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .en     (en),
        .e      (e),
        .limite (limite),
        .q      (q),
        .q_bar  (q_bar),
        .busy   (busy),
        .done   (done),
        .tc     (tc)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic ld, input logic en_i,
                                input logic [6:0] e_i, input logic [6:0] lim,
                                input logic [6:0] q_e, input logic b_e,
                                input logic d_e, input logic tc_e);
        vec_t v;
        v.rst = r; v.load = ld; v.en = en_i; v.e = e_i; v.limite = lim;
        v.q = q_e; v.busy = b_e; v.done = d_e; v.tc = tc_e;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one vector on the falling edge, queue its expectation, compare after the edge
    task automatic apply(input vec_t v, input int idx);
        vec_t exp_v;
        @(negedge clk);
        rst = v.rst; load = v.load; en = v.en; e = v.e; limite = v.limite;
        sb.push_back(v);
        @(posedge clk);
        #1;
        exp_v = sb.pop_front();
        check($sformatf("v%0d.q", idx),     q,     exp_v.q);
        check($sformatf("v%0d.q_bar", idx), q_bar, 7'h7F ^ exp_v.q);
        check($sformatf("v%0d.busy", idx),  busy,  exp_v.busy);
        check($sformatf("v%0d.done", idx),  done,  exp_v.done);
        check($sformatf("v%0d.tc", idx),    tc,    exp_v.tc);
    endtask

    initial begin
        int tc_count;
        int first_tc;
        int done_seen;

        //                 rst ld en  e     lim    q      busy done tc
`ifndef CONTADOR_ASC_AUTO_RECARGA_EN
        // Reset then count to 3
        vecs.push_back(mk(1, 0, 0, 7'd0,   7'd0,  7'd0,   0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 7'd0,   7'd3,  7'd1,   1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 7'd0,   7'd3,  7'd2,   1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 7'd0,   7'd3,  7'd3,   1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 7'd0,   7'd3,  7'd3,   0, 1, 1));
        vecs.push_back(mk(0, 0, 1, 7'd0,   7'd3,  7'd3,   0, 1, 0));
        // Load 10, limit 12
        vecs.push_back(mk(0, 1, 0, 7'd10,  7'd12, 7'd10,  0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 7'd0,   7'd12, 7'd11,  1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 7'd0,   7'd12, 7'd12,  1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 7'd0,   7'd12, 7'd12,  0, 1, 1));
        vecs.push_back(mk(0, 0, 1, 7'd0,   7'd12, 7'd12,  0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 7'd0,   7'd12, 7'd12,  0, 1, 0));
        // Pause for 3 cycles, then load+en together
        vecs.push_back(mk(0, 1, 0, 7'd20,  7'd30, 7'd20,  0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 7'd0,   7'd30, 7'd21,  1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 7'd0,   7'd30, 7'd21,  1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 7'd0,   7'd30, 7'd21,  1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 7'd0,   7'd30, 7'd21,  1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 7'd5,   7'd30, 7'd5,   0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 7'd0,   7'd30, 7'd5,   0, 0, 0));
        // e == limite from IDLE: tc with zero increments
        vecs.push_back(mk(0, 1, 0, 7'd8,   7'd8,  7'd8,   0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 7'd0,   7'd8,  7'd8,   0, 1, 1));
        // Wrap 126 -> 127 -> 0 -> 1
        vecs.push_back(mk(0, 1, 0, 7'd126, 7'd1,  7'd126, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 7'd0,   7'd1,  7'd127, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 7'd0,   7'd1,  7'd0,   1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 7'd0,   7'd1,  7'd1,   1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 7'd0,   7'd1,  7'd1,   0, 1, 1));
        // limite changed mid-count
        vecs.push_back(mk(0, 1, 0, 7'd10,  7'd20, 7'd10,  0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 7'd0,   7'd20, 7'd11,  1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 7'd0,   7'd5,  7'd12,  1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 7'd0,   7'd12, 7'd12,  0, 1, 1));
        // rst + load together mid-count
        vecs.push_back(mk(0, 1, 0, 7'd5,   7'd40, 7'd5,   0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 7'd0,   7'd40, 7'd6,   1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 7'd0,   7'd40, 7'd7,   1, 0, 0));
        vecs.push_back(mk(1, 1, 1, 7'd50,  7'd40, 7'd0,   0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 7'd0,   7'd0,  7'd0,   0, 1, 1));
`else
        // Reset, then continuous 2 -> 3 -> 4 -> 2 ...
        vecs.push_back(mk(1, 0, 0, 7'd0,   7'd0,  7'd0,   0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 7'd2,   7'd4,  7'd2,   0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 7'd0,   7'd4,  7'd3,   1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 7'd0,   7'd4,  7'd4,   1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 7'd0,   7'd4,  7'd2,   1, 0, 1));
        vecs.push_back(mk(0, 0, 1, 7'd0,   7'd4,  7'd3,   1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 7'd0,   7'd4,  7'd4,   1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 7'd0,   7'd4,  7'd2,   1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 7'd0,   7'd4,  7'd2,   1, 0, 0));
        // rst + load together: carga must become 0
        vecs.push_back(mk(0, 1, 0, 7'd5,   7'd9,  7'd5,   0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 7'd0,   7'd9,  7'd6,   1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 7'd0,   7'd9,  7'd7,   1, 0, 0));
        vecs.push_back(mk(1, 1, 1, 7'd50,  7'd9,  7'd0,   0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 7'd0,   7'd2,  7'd1,   1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 7'd0,   7'd2,  7'd2,   1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 7'd0,   7'd2,  7'd0,   1, 0, 1));
        vecs.push_back(mk(0, 0, 1, 7'd0,   7'd2,  7'd1,   1, 0, 0));
        // Wrap then reload
        vecs.push_back(mk(0, 1, 0, 7'd126, 7'd0,  7'd126, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 7'd0,   7'd0,  7'd127, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 7'd0,   7'd0,  7'd0,   1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 7'd0,   7'd0,  7'd126, 1, 0, 1));
`endif

        foreach (vecs[i]) apply(vecs[i], i);

        // Long run: count tc pulses over a bounded window
        @(negedge clk);
        rst = 1'b0; load = 1'b1; en = 1'b0;
`ifndef CONTADOR_ASC_AUTO_RECARGA_EN
        e = 7'd0; limite = 7'd50;
`else
        e = 7'd2; limite = 7'd4;
`endif
        @(negedge clk);
        load = 1'b0; en = 1'b1;
        tc_count = 0; first_tc = -1; done_seen = 0;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk);
            #1;
            if (tc) begin
                tc_count++;
                if (first_tc < 0) first_tc = c;
            end
            if (done) done_seen++;
        end
        en = 1'b0;
`ifndef CONTADOR_ASC_AUTO_RECARGA_EN
        check("run.tc_count", tc_count, 1);
        check("run.first_tc", first_tc, 51);
        check("run.q_final", q, 50);
        check("run.done_final", done, 1);
`else
        check("run.tc_count", tc_count, 20);
        check("run.first_tc", first_tc, 3);
        check("run.done_seen", done_seen, 0);
        check("run.busy_final", busy, 1);
`endif

        check("sb.empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
